instr_fetch: RTL and testbench

//  Fetch stage, producer side of the instr_reg pipeline register. Holds the PC and issues word

---
 rtl/instr_fetch.sv | 119 +++++++++++
 tb/tb_instr_fetch.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Fetch stage: issues word reads to the L1 I-cache and feeds instr_reg via an output slot
// backed by a one-entry skid buffer. A redirect drains any L1 access that is still in flight.
module instr_fetch #(
  parameter int               n         = 32,
  parameter logic [n-1:0]     RESET_PC  = '0,
  parameter logic [n-1:0]     INSTR_NOP = 32'h0000_0013
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         L1_busy,
  input  logic [n-1:0] L1_rdata,
  output logic         L1_req,
  output logic [n-1:0] L1_addr,
  input  logic         stall,
  input  logic         redirect,
  input  logic [n-1:0] redirect_pc,
  output logic [n-1:0] instruction_next,
  output logic [n-1:0] pc_next,
  output logic [n-1:0] pc_plus_four_next,
  output logic         fetch_valid
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t       state_q;
  logic [n-1:0] pc_q, addr_q, instr_q, pcn_q, pc4_q, skid_instr_q, skid_pc_q;
  logic         req_q, fv_q, skid_v_q;

  logic         complete, consume;
  logic [n-1:0] tgt, pc_inc, addr_inc;

  assign complete = req_q & ~L1_busy;
  assign consume  = fv_q & ~stall;
  assign tgt      = redirect_pc & ~n'(3);
  assign pc_inc   = pc_q + n'(4);
  assign addr_inc = addr_q + n'(4);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      req_q        <= 1'b0;
      addr_q       <= RESET_PC;
      fv_q         <= 1'b0;
      instr_q      <= INSTR_NOP;
      pcn_q        <= '0;
      pc4_q        <= '0;
      skid_v_q     <= 1'b0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q <= FETCH;
          req_q   <= 1'b1;
          addr_q  <= pc_q;
        end
        FETCH: begin
          if (redirect) begin
            pc_q     <= tgt;
            fv_q     <= 1'b0;
            instr_q  <= INSTR_NOP;
            skid_v_q <= 1'b0;
            // A busy access must finish on the bus before the new PC may be requested.
            if (req_q && L1_busy) state_q <= DRAIN;
            else begin
              req_q  <= 1'b1;
              addr_q <= tgt;
            end
          end else if (complete) begin
            pc_q   <= pc_inc;
            addr_q <= pc_inc;
            if (!fv_q || consume) begin
              fv_q    <= 1'b1;
              instr_q <= L1_rdata;
              pcn_q   <= addr_q;
              pc4_q   <= addr_inc;
              req_q   <= 1'b1;
            end else begin
              // Slot still held: park the word and stop requesting until it drains.
              skid_v_q     <= 1'b1;
              skid_instr_q <= L1_rdata;
              skid_pc_q    <= addr_q;
              req_q        <= 1'b0;
            end
          end else if (consume) begin
            if (skid_v_q) begin
              instr_q  <= skid_instr_q;
              pcn_q    <= skid_pc_q;
              pc4_q    <= skid_pc_q + n'(4);
              skid_v_q <= 1'b0;
              req_q    <= 1'b1;
              addr_q   <= pc_q;
            end else begin
              fv_q    <= 1'b0;
              instr_q <= INSTR_NOP;
            end
          end
        end
        DRAIN: begin
          if (redirect) pc_q <= tgt;
          if (complete) begin
            state_q <= FETCH;
            addr_q  <= redirect ? tgt : pc_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign L1_req            = req_q;
  assign L1_addr           = addr_q;
  assign fetch_valid       = fv_q;
  assign instruction_next  = instr_q;
  assign pc_next           = pcn_q;
  assign pc_plus_four_next = pc4_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: queue-based reference model compared every cycle, plus directed
// literal expectations and a second instance exercising PC wrap and async reset in DRAIN.
module tb_instr_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst, busy, stall, redir;
  logic [31:0] rdata, rpc;
  logic        req, fv;
  logic [31:0] addr, ins, pcn, pc4;

  logic        rst2, busy2, stall2, redir2;
  logic [31:0] rdata2, rpc2;
  logic        req2, fv2;
  logic [31:0] addr2, ins2, pcn2, pc42;

  instr_fetch #(.n(32), .RESET_PC(32'h0), .INSTR_NOP(NOP)) u_dut (
    .clk(clk), .reset(rst), .L1_busy(busy), .L1_rdata(rdata), .L1_req(req), .L1_addr(addr),
    .stall(stall), .redirect(redir), .redirect_pc(rpc), .instruction_next(ins),
    .pc_next(pcn), .pc_plus_four_next(pc4), .fetch_valid(fv));

  instr_fetch #(.n(32), .RESET_PC(32'hFFFF_FFFC), .INSTR_NOP(NOP)) u_dut2 (
    .clk(clk), .reset(rst2), .L1_busy(busy2), .L1_rdata(rdata2), .L1_req(req2), .L1_addr(addr2),
    .stall(stall2), .redirect(redir2), .redirect_pc(rpc2), .instruction_next(ins2),
    .pc_next(pcn2), .pc_plus_four_next(pc42), .fetch_valid(fv2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_pass = 0;
  int n_tot  = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Reference model: queue holds slot (front) and skid (back), at most two entries.
  typedef struct packed { logic [31:0] ins; logic [31:0] pc; } ent_t;
  ent_t        q[$];
  logic [31:0] m_pc, m_addr, m_last, m_last4;
  bit          m_req, m_idle, m_drain;

  task automatic mreset();
    q.delete();
    m_pc = 32'h0; m_addr = 32'h0; m_last = 32'h0; m_last4 = 32'h0;
    m_req = 1'b0; m_idle = 1'b1; m_drain = 1'b0;
  endtask

  task automatic mstep();
    bit cpl, cons;
    cpl  = m_req && !busy;
    cons = (q.size() > 0) && !stall;
    if (m_idle) begin
      m_idle = 1'b0; m_req = 1'b1; m_addr = m_pc;
    end else begin
      if (cons) void'(q.pop_front());
      if (redir) begin
        q.delete();
        m_pc = {rpc[31:2], 2'b00};
        if (m_req && busy) m_drain = 1'b1;
        else begin m_drain = 1'b0; m_req = 1'b1; m_addr = m_pc; end
      end else if (cpl) begin
        if (!m_drain) begin
          q.push_back('{ins: rdata, pc: m_addr});
          m_pc = m_pc + 32'd4;
        end
        m_drain = 1'b0;
        m_req   = (q.size() < 2);
        m_addr  = m_pc;
      end else if (!m_req) begin
        m_req  = (q.size() < 2);
        m_addr = m_pc;
      end
      if (q.size() > 0) begin m_last = q[0].pc; m_last4 = q[0].pc + 32'd4; end
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_valid", {31'b0, fv}, {31'b0, q.size() > 0});
      chk("m_instr", ins, (q.size() > 0) ? q[0].ins : NOP);
      chk("m_pc_next", pcn, m_last);
      chk("m_pc4", pc4, m_last4);
      chk("m_req", {31'b0, req}, {31'b0, m_req});
      if (m_req) chk("m_addr", addr, m_addr);
    end
  end

  task automatic step(input logic b, input logic [31:0] d, input logic s,
                      input logic r, input logic [31:0] rp);
    busy = b; rdata = d; stall = s; redir = r; rpc = rp;
    @(posedge clk);
    mstep();
    #2;
  endtask

  initial begin
    rst = 1'b1; busy = 1'b1; stall = 1'b0; redir = 1'b0; rdata = '0; rpc = '0;
    rst2 = 1'b1; busy2 = 1'b1; stall2 = 1'b0; redir2 = 1'b0; rdata2 = '0; rpc2 = '0;
    mreset();
    #1 rst = 1'b0; rst2 = 1'b0;
    chk_en = 1'b1;
    #2;
    chk("rst_req", {31'b0, req}, 32'd0);
    chk("rst_addr", addr, 32'd0);
    chk("rst_valid", {31'b0, fv}, 32'd0);
    chk("rst_instr", ins, NOP);
    @(posedge clk); #2;
    rst = 1'b1;
    #1 chk("idle_req", {31'b0, req}, 32'd0);

    // Test 1/2: first request, two busy cycles, then completion.
    step(1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("t1_req", {31'b0, req}, 32'd1);
    chk("t1_addr", addr, 32'd0);
    chk("t1_instr", ins, NOP);
    step(1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("t2_busy_addr", addr, 32'd0);
    step(1'b0, 32'd55, 1'b0, 1'b0, 32'h0);
    chk("t2_instr", ins, 32'd55);
    chk("t2_pc", pcn, 32'd0);
    chk("t2_pc4", pc4, 32'd4);
    chk("t2_valid", {31'b0, fv}, 32'd1);
    chk("t2_addr", addr, 32'd4);

    // Test 3: stall fills the skid and drops the request; one unstalled cycle drains it.
    step(1'b0, 32'd66, 1'b1, 1'b0, 32'h0);
    chk("t3_req_drop", {31'b0, req}, 32'd0);
    chk("t3_slot", ins, 32'd55);
    step(1'b0, 32'd0, 1'b1, 1'b0, 32'h0);
    chk("t3_hold", pcn, 32'd0);
    step(1'b1, 32'd0, 1'b0, 1'b0, 32'h0);
    chk("t3_skid_out", ins, 32'd66);
    chk("t3_skid_pc", pcn, 32'd4);
    chk("t3_req", {31'b0, req}, 32'd1);
    chk("t3_addr", addr, 32'd8);
    step(1'b1, 32'd0, 1'b1, 1'b0, 32'h0);

    // Test 4: redirect while busy -> drain, old data discarded.
    step(1'b1, 32'd0, 1'b1, 1'b1, 32'd250);
    chk("t4_drain_addr", addr, 32'd8);
    chk("t4_valid", {31'b0, fv}, 32'd0);
    step(1'b1, 32'd0, 1'b1, 1'b0, 32'h0);
    step(1'b0, 32'hDEAD, 1'b0, 1'b0, 32'h0);
    chk("t4_valid2", {31'b0, fv}, 32'd0);
    chk("t4_new_addr", addr, 32'd248);
    step(1'b0, 32'd77, 1'b0, 1'b0, 32'h0);
    chk("t4_instr", ins, 32'd77);
    chk("t4_pc", pcn, 32'd248);

    // Test 5: redirect + stall + completion in one cycle.
    step(1'b0, 32'd88, 1'b1, 1'b1, 32'h103);
    chk("t5_valid", {31'b0, fv}, 32'd0);
    chk("t5_addr", addr, 32'h100);
    step(1'b0, 32'd99, 1'b0, 1'b0, 32'h0);
    chk("t5_instr", ins, 32'd99);
    chk("t5_pc4", pc4, 32'h104);

    // Mixed traffic checked by the model.
    for (int i = 0; i < 300; i++)
      step(($urandom % 3) == 0, $urandom, ($urandom % 3) == 0, ($urandom % 15) == 0, $urandom);

    // Test 6: PC wrap and async reset while draining, on the second instance.
    chk_en = 1'b0;
    rst2 = 1'b1;
    @(posedge clk); #2;
    chk("t6_req", {31'b0, req2}, 32'd1);
    chk("t6_addr", addr2, 32'hFFFF_FFFC);
    busy2 = 1'b0; rdata2 = 32'hABC;
    @(posedge clk); #2;
    chk("t6_pc", pcn2, 32'hFFFF_FFFC);
    chk("t6_pc4_wrap", pc42, 32'd0);
    chk("t6_addr_wrap", addr2, 32'd0);
    busy2 = 1'b1; redir2 = 1'b1; rpc2 = 32'h40;
    @(posedge clk); #2;
    redir2 = 1'b0;
    chk("t6_drain_req", {31'b0, req2}, 32'd1);
    chk("t6_drain_addr", addr2, 32'd0);
    #1 rst2 = 1'b0;
    #1;
    chk("t6_arst_req", {31'b0, req2}, 32'd0);
    chk("t6_arst_addr", addr2, 32'hFFFF_FFFC);
    chk("t6_arst_instr", ins2, NOP);
    chk("t6_arst_pc4", pc42, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
